// File: rtl/tawas_div_sched.sv
// tawas_div_sched: round-robin scheduler and shared radix-2^k restoring divider
// for the four Tawas threads; results wait in per-thread slots for their slice.
module tawas_div_sched #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  slice_i,
    input  logic        req_vld_i,
    input  logic [1:0]  req_op_i,
    input  logic [2:0]  req_rd_i,
    input  logic [31:0] req_a_i,
    input  logic [31:0] req_b_i,
    input  logic        flush_i,
    output logic [3:0]  busy_o,
    output logic        req_drop_o,
    output logic        rc_vld_o,
    output logic [1:0]  rc_thread_o,
    output logic [2:0]  rc_sel_o,
    output logic [31:0] rc_o,
    output logic        rc_dz_o,
    output logic        rc_ovf_o
);
    localparam int ITERS = 32 / BITS_PER_CYCLE;
    typedef enum logic [1:0] {S_IDLE, S_PEND, S_RUN, S_DONE} slot_e;
    typedef enum logic [1:0] {E_IDLE, E_RUN, E_FIX} eng_e;

    slot_e       slot_q [4];
    logic [1:0]  op_q [4];
    logic [2:0]  rd_q [4];
    logic [31:0] a_q [4];
    logic [31:0] b_q [4];
    logic [31:0] res_q [4];
    logic [3:0]  dz_q, ovf_q;
    eng_e        eng_q;
    logic [1:0]  rr_q, own_q, eop_q;
    logic [5:0]  cnt_q;
    logic [31:0] q_q, d_q;
    logic [32:0] r_q;
    logic        sa_q, sb_q, edz_q, eovf_q;

    logic [3:0]  pend;
    logic        gnt_vld, dlv, acc, abort, g_sgn, g_dz, g_ovf;
    logic [1:0]  gnt_t;
    logic [31:0] g_a, g_b, q_d, qf, rf;
    logic [32:0] r_d;

    assign dlv   = slot_q[slice_i] == S_DONE && !flush_i;
    assign acc   = req_vld_i && !flush_i && (slot_q[slice_i] == S_IDLE || dlv);
    assign abort = flush_i && slice_i == own_q && eng_q != E_IDLE;
    assign qf    = (sa_q ^ sb_q) ? -q_q : q_q;
    assign rf    = sa_q ? -r_q[31:0] : r_q[31:0];

    always_comb begin
        for (int t = 0; t < 4; t++) begin
            pend[t]   = slot_q[t] == S_PEND && !(flush_i && slice_i == 2'(t));
            busy_o[t] = slot_q[t] != S_IDLE;
        end
        // Descending scan so rr+1 overrides: priority rr+1, rr+2, rr+3, rr.
        gnt_t = rr_q;
        for (int i = 4; i >= 1; i--)
            if (pend[rr_q + 2'(i)]) gnt_t = rr_q + 2'(i);
        gnt_vld = eng_q == E_IDLE && |pend;
        g_a   = a_q[gnt_t];
        g_b   = b_q[gnt_t];
        g_sgn = op_q[gnt_t][0];
        g_dz  = g_b == 32'd0;
        g_ovf = g_sgn && g_a == 32'h8000_0000 && g_b == 32'hFFFF_FFFF;
        q_d = q_q;
        r_d = r_q;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            r_d = {r_d[31:0], q_d[31]};
            q_d = {q_d[30:0], 1'b0};
            if (r_d >= {1'b0, d_q}) begin
                r_d     = r_d - {1'b0, d_q};
                q_d[0]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int t = 0; t < 4; t++) begin
                slot_q[t] <= S_IDLE;
                op_q[t]   <= '0;
                rd_q[t]   <= '0;
                a_q[t]    <= '0;
                b_q[t]    <= '0;
                res_q[t]  <= '0;
            end
            dz_q        <= '0;
            ovf_q       <= '0;
            eng_q       <= E_IDLE;
            rr_q        <= '0;
            own_q       <= '0;
            eop_q       <= '0;
            cnt_q       <= '0;
            q_q         <= '0;
            d_q         <= '0;
            r_q         <= '0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            edz_q       <= 1'b0;
            eovf_q      <= 1'b0;
            req_drop_o  <= 1'b0;
            rc_vld_o    <= 1'b0;
            rc_thread_o <= '0;
            rc_sel_o    <= '0;
            rc_o        <= '0;
            rc_dz_o     <= 1'b0;
            rc_ovf_o    <= 1'b0;
        end else begin
            req_drop_o <= req_vld_i && !flush_i && !acc;
            rc_vld_o   <= dlv;
            if (dlv) begin
                rc_thread_o     <= slice_i;
                rc_sel_o        <= rd_q[slice_i];
                rc_o            <= res_q[slice_i];
                rc_dz_o         <= dz_q[slice_i];
                rc_ovf_o        <= ovf_q[slice_i];
                slot_q[slice_i] <= S_IDLE;
            end
            if (acc) begin
                slot_q[slice_i] <= S_PEND;
                op_q[slice_i]   <= req_op_i;
                rd_q[slice_i]   <= req_rd_i;
                a_q[slice_i]    <= req_a_i;
                b_q[slice_i]    <= req_b_i;
            end
            if (flush_i) slot_q[slice_i] <= S_IDLE;
            if (eng_q == E_IDLE) begin
                if (gnt_vld) begin
                    rr_q          <= gnt_t;
                    own_q         <= gnt_t;
                    slot_q[gnt_t] <= S_RUN;
                    eop_q         <= op_q[gnt_t];
                    edz_q         <= g_dz;
                    eovf_q        <= g_ovf;
                    cnt_q         <= 6'(ITERS);
                    // Special cases preload the final q/r unsigned so FIXUP passes them through.
                    if (g_dz || g_ovf) begin
                        q_q   <= g_dz ? 32'hFFFF_FFFF : 32'h8000_0000;
                        r_q   <= g_dz ? {1'b0, g_a} : 33'd0;
                        sa_q  <= 1'b0;
                        sb_q  <= 1'b0;
                        eng_q <= E_FIX;
                    end else begin
                        q_q   <= (g_sgn && g_a[31]) ? -g_a : g_a;
                        d_q   <= (g_sgn && g_b[31]) ? -g_b : g_b;
                        r_q   <= '0;
                        sa_q  <= g_sgn && g_a[31];
                        sb_q  <= g_sgn && g_b[31];
                        eng_q <= E_RUN;
                    end
                end
            end else if (abort) begin
                eng_q <= E_IDLE;
            end else if (eng_q == E_RUN) begin
                q_q   <= q_d;
                r_q   <= r_d;
                cnt_q <= cnt_q - 6'd1;
                if (cnt_q == 6'd1) eng_q <= E_FIX;
            end else begin
                res_q[own_q]  <= eop_q[1] ? rf : qf;
                dz_q[own_q]   <= edz_q;
                ovf_q[own_q]  <= eovf_q;
                slot_q[own_q] <= S_DONE;
                eng_q         <= E_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_tawas_div_sched.sv
// tb_tawas_div_sched: directed bench with per-thread scoreboard queues and a reference divide model.
module tb_tawas_div_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  slice_i = '0;
    logic        req_vld_i = 1'b0;
    logic [1:0]  req_op_i = '0;
    logic [2:0]  req_rd_i = '0;
    logic [31:0] req_a_i = '0;
    logic [31:0] req_b_i = '0;
    logic        flush_i = 1'b0;
    logic [3:0]  busy_o;
    logic        req_drop_o, rc_vld_o, rc_dz_o, rc_ovf_o;
    logic [1:0]  rc_thread_o;
    logic [2:0]  rc_sel_o;
    logic [31:0] rc_o;

    typedef struct packed {
        logic [2:0]  sel;
        logic [31:0] val;
        logic        dz;
        logic        ovf;
    } exp_t;

    exp_t       exp_q [4][$];
    logic [1:0] dlv_order [$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         acc_cyc [4];
    int         dlv_cyc [4];
    int         flush_cyc;

    tawas_div_sched #(.BITS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .slice_i(slice_i), .req_vld_i(req_vld_i), .req_op_i(req_op_i),
        .req_rd_i(req_rd_i), .req_a_i(req_a_i), .req_b_i(req_b_i), .flush_i(flush_i),
        .busy_o(busy_o), .req_drop_o(req_drop_o), .rc_vld_o(rc_vld_o), .rc_thread_o(rc_thread_o),
        .rc_sel_o(rc_sel_o), .rc_o(rc_o), .rc_dz_o(rc_dz_o), .rc_ovf_o(rc_ovf_o)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [1:0] op, input logic [2:0] rd, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [31:0] q, r;
        e.sel = rd;
        e.dz  = 1'b0;
        e.ovf = 1'b0;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; e.dz = 1'b1;
        end else if (op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 32'd0; e.ovf = 1'b1;
        end else if (op[0]) begin
            q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
        end else begin
            q = a / b; r = a % b;
        end
        e.val = op[1] ? r : q;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out();
        exp_t e;
        if (rc_vld_o) begin
            dlv_cyc[rc_thread_o] = cyc;
            dlv_order.push_back(rc_thread_o);
            chk("rc_thread_vs_slice", 64'(rc_thread_o), 64'(slice_i));
            chk("rc_expected", 64'(exp_q[rc_thread_o].size() > 0), 64'd1);
            if (exp_q[rc_thread_o].size() > 0) begin
                e = exp_q[rc_thread_o].pop_front();
                chk($sformatf("rc_payload_t%0d", rc_thread_o), 64'({rc_sel_o, rc_o, rc_dz_o, rc_ovf_o}), 64'(e));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        chk_out();
        slice_i = slice_i + 2'd1;
    endtask

    task automatic issue(input logic [1:0] t, input logic [1:0] op, input logic [2:0] rd,
                         input logic [31:0] a, input logic [31:0] b, input bit acc);
        while (slice_i != t) tick();
        req_vld_i = 1'b1;
        req_op_i  = op;
        req_rd_i  = rd;
        req_a_i   = a;
        req_b_i   = b;
        if (acc) exp_q[t].push_back(model(op, rd, a, b));
        tick();
        req_vld_i = 1'b0;
        if (acc) acc_cyc[t] = cyc;
        chk($sformatf("req_drop_t%0d", t), 64'(req_drop_o), 64'(!acc));
    endtask

    task automatic wait_done(input logic [1:0] t, input int budget);
        int n = 0;
        while (exp_q[t].size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk($sformatf("done_t%0d", t), 64'(exp_q[t].size()), 64'd0);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_vld_i = 1'b0;
        flush_i   = 1'b0;
        #2;
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_vld_drop", 64'({rc_vld_o, req_drop_o}), 64'd0);
        chk("rst_rc", 64'({rc_thread_o, rc_sel_o, rc_o, rc_dz_o, rc_ovf_o}), 64'd0);
        for (int t = 0; t < 4; t++) exp_q[t].delete();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #1;
        do_reset();
        // T0: unsigned 100/7 quotient then remainder
        issue(2'd0, 2'b00, 3'd3, 32'd100, 32'd7, 1);
        wait_done(2'd0, 60);
        chk("t0_latency", 64'(dlv_cyc[0] - acc_cyc[0]), 64'd36);
        issue(2'd0, 2'b10, 3'd4, 32'd100, 32'd7, 1);
        wait_done(2'd0, 60);
        // T1: signed cases
        issue(2'd0, 2'b01, 3'd1, 32'hFFFF_FFF9, 32'd2, 1);
        wait_done(2'd0, 60);
        issue(2'd0, 2'b11, 3'd2, 32'hFFFF_FFF9, 32'd2, 1);
        wait_done(2'd0, 60);
        issue(2'd0, 2'b01, 3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        wait_done(2'd0, 60);
        chk("t1_ovf_latency", 64'(dlv_cyc[0] - acc_cyc[0]), 64'd4);
        // T2: divide by zero
        issue(2'd1, 2'b00, 3'd5, 32'h1234, 32'd0, 1);
        wait_done(2'd1, 60);
        chk("t2_dz_latency", 64'(dlv_cyc[1] - acc_cyc[1]), 64'd4);
        issue(2'd1, 2'b10, 3'd6, 32'h1234, 32'd0, 1);
        wait_done(2'd1, 60);
        // T4: drop while busy, then flush thread 2 mid-RUN with thread 1 pending
        issue(2'd2, 2'b00, 3'd1, 32'd1000, 32'd3, 1);
        issue(2'd2, 2'b11, 3'd7, 32'd5, 32'd5, 0);
        tick();
        chk("t4_drop_pulse_end", 64'(req_drop_o), 64'd0);
        issue(2'd1, 2'b00, 3'd2, 32'd777, 32'd5, 1);
        while (slice_i != 2'd2) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        flush_cyc = cyc;
        exp_q[2].delete();
        chk("t4_busy_after_flush", 64'(busy_o[2:1]), 64'b01);
        wait_done(2'd1, 60);
        chk("t4_regrant_latency", 64'(dlv_cyc[1] - flush_cyc), 64'd35);
        repeat (8) tick();
        // T5: reset mid-run, then a fresh request
        issue(2'd3, 2'b00, 3'd6, 32'hDEAD_BEEF, 32'd17, 1);
        repeat (11) tick();
        do_reset();
        issue(2'd3, 2'b01, 3'd6, 32'hFFFF_FF9C, 32'd7, 1);
        wait_done(2'd3, 60);
        // T3: four threads in consecutive slices after reset
        do_reset();
        dlv_order.delete();
        issue(2'd1, 2'b00, 3'd1, 32'd100, 32'd7, 1);
        issue(2'd2, 2'b11, 3'd2, 32'hFFFF_FFCE, 32'd3, 1);
        issue(2'd3, 2'b00, 3'd3, 32'hFFFF_FFFF, 32'h10, 1);
        issue(2'd0, 2'b10, 3'd4, 32'd12345, 32'd0, 1);
        for (int t = 0; t < 4; t++) wait_done(2'(t), 200);
        chk("t3_order_len", 64'(dlv_order.size()), 64'd4);
        for (int i = 0; i < 4 && i < dlv_order.size(); i++)
            chk($sformatf("t3_order%0d", i), 64'(dlv_order[i]), 64'((i + 1) % 4));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
